// File: rtl/crc_serial_appender.sv
// LSB-first packet serialiser that appends a complemented USB CRC5 or CRC16, MSB first.
// The CRC covers every bit after the PID. CRC mode and length are captured when the packet is accepted.
module crc_serial_appender #(
  parameter int MAX_BITS = 100,
  parameter int PID_BITS = 8,
  parameter int LEN_W    = 7
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                pkt_valid,
  output logic                pkt_ready,
  input  logic [MAX_BITS-1:0] pkt_in,
  input  logic [LEN_W-1:0]    pkt_len,
  input  logic                crc_en,
  input  logic                crc16,
  input  logic                bs_ready,
  output logic                out_bit,
  output logic                out_valid,
  output logic                out_last,
  output logic                done,
  output logic                len_err
);

  typedef enum logic [1:0] {IDLE, SEND_PKT, SEND_CRC, DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [MAX_BITS-1:0] r_shift;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_bit_cnt;
  logic                r_crc_en;
  logic                r_crc16;
  logic                r_ready_en;
  logic                r_len_err;
  logic [15:0]         r_crc;
  logic [3:0]          r_k;

  logic                w_accept;
  logic                w_len_ok;
  logic                w_xfer;
  logic                w_pkt_last;
  logic                w_crc_last;
  logic [3:0]          w_crc_top;
  logic [3:0]          w_crc_idx;

  // One LFSR step. In CRC5 mode only bits [4:0] are meaningful.
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic bit_in,
                                           input logic is16);
    logic fb;
    if (is16) begin
      fb = bit_in ^ crc[15];
      return {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end else begin
      fb = bit_in ^ crc[4];
      return {11'd0, crc[3:0], 1'b0} ^ (fb ? 16'h0005 : 16'h0000);
    end
  endfunction

  assign pkt_ready  = r_ready_en && (r_state == IDLE);
  assign len_err    = r_len_err;
  assign w_accept   = pkt_valid && pkt_ready;
  assign w_len_ok   = (pkt_len != '0) && (pkt_len <= LEN_W'(MAX_BITS));
  assign w_xfer     = bs_ready && ((r_state == SEND_PKT) || (r_state == SEND_CRC));
  assign w_pkt_last = (r_bit_cnt == (r_len - LEN_W'(1)));
  assign w_crc_top  = r_crc16 ? 4'd15 : 4'd4;
  assign w_crc_last = (r_k == w_crc_top);
  assign w_crc_idx  = w_crc_top - r_k;

  always_comb begin
    w_next    = r_state;
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_last  = 1'b0;
    done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept && w_len_ok) w_next = SEND_PKT;
      end
      SEND_PKT: begin
        out_valid = 1'b1;
        out_bit   = r_shift[0];
        out_last  = w_pkt_last && !r_crc_en;
        if (bs_ready && w_pkt_last) w_next = r_crc_en ? SEND_CRC : DONE;
      end
      SEND_CRC: begin
        out_valid = 1'b1;
        out_bit   = ~r_crc[w_crc_idx];
        out_last  = w_crc_last;
        if (bs_ready && w_crc_last) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_ready_en <= 1'b0;
      r_len_err  <= 1'b0;
      r_shift    <= '0;
      r_len      <= '0;
      r_bit_cnt  <= '0;
      r_crc_en   <= 1'b0;
      r_crc16    <= 1'b0;
      r_crc      <= 16'hFFFF;
      r_k        <= '0;
    end else begin
      r_state    <= w_next;
      r_ready_en <= 1'b1;
      r_len_err  <= w_accept && !w_len_ok;
      if (w_accept) begin
        r_shift   <= pkt_in;
        r_len     <= pkt_len;
        r_crc_en  <= crc_en;
        r_crc16   <= crc16;
        r_crc     <= 16'hFFFF;
        r_bit_cnt <= '0;
        r_k       <= '0;
      end else if (w_xfer) begin
        if (r_state == SEND_PKT) begin
          r_shift   <= r_shift >> 1;
          r_bit_cnt <= r_bit_cnt + LEN_W'(1);
          // PID bits go on the wire but are excluded from the CRC.
          if (r_bit_cnt >= LEN_W'(PID_BITS)) r_crc <= crc_step(r_crc, r_shift[0], r_crc16);
        end else begin
          r_k <= r_k + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_crc_serial_appender.sv
// Randomised bench for crc_serial_appender. A queue-based reference builds the expected bit stream.
// Received CRCs are also checked against the fixed USB residuals.
module tb_crc_serial_appender;
  localparam int MAX_BITS = 100;
  localparam int PID_BITS = 8;
  localparam int LEN_W    = 7;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic                pkt_valid = 1'b0;
  logic [MAX_BITS-1:0] pkt_in = '0;
  logic [LEN_W-1:0]    pkt_len = '0;
  logic                crc_en = 1'b0;
  logic                crc16 = 1'b0;
  logic                bs_ready = 1'b0;
  logic                pkt_ready, out_bit, out_valid, out_last, done, len_err;

  int n_chk  = 0;
  int n_pass = 0;
  bit got[$];
  bit want_q[$];
  int last_pos;

  crc_serial_appender #(.MAX_BITS(MAX_BITS), .PID_BITS(PID_BITS), .LEN_W(LEN_W)) dut (
    .clock(clock), .reset_n(reset_n), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_in(pkt_in), .pkt_len(pkt_len), .crc_en(crc_en), .crc16(crc16),
    .bs_ready(bs_ready), .out_bit(out_bit), .out_valid(out_valid), .out_last(out_last),
    .done(done), .len_err(len_err)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
    n_chk++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, want);
  endtask

  // CRC register after feeding q[from..] into a register preset to all ones.
  function automatic logic [15:0] crc_over(input bit q[$], input int from, input bit is16);
    logic [15:0] poly, mask, r;
    int          n;
    bit          fb;
    n    = is16 ? 16 : 5;
    poly = is16 ? 16'h8005 : 16'h0005;
    mask = is16 ? 16'hFFFF : 16'h001F;
    r    = mask;
    for (int i = from; i < q.size(); i++) begin
      fb = q[i] ^ r[n-1];
      r  = ((r << 1) & mask) ^ (fb ? poly : 16'h0000);
    end
    return r;
  endfunction

  function automatic void build_want(input logic [MAX_BITS-1:0] p, input int len,
                                     input bit ce, input bit c16);
    logic [15:0] c;
    int          n;
    want_q.delete();
    for (int i = 0; i < len; i++) want_q.push_back(p[i]);
    if (ce) begin
      n = c16 ? 16 : 5;
      c = crc_over(want_q, PID_BITS, c16);
      for (int k = n - 1; k >= 0; k--) want_q.push_back(~c[k]);
    end
  endfunction

  // mode 0: bs_ready held high; 1: random; 2: single stalls in PID, data and CRC, then random.
  task automatic run_pkt(input logic [MAX_BITS-1:0] p, input int len, input bit ce, input bit c16,
                         input int mode, input bit noise, input int abort_at, input string tag);
    int          cyc, n;
    bit          fin, prev_hold, prev_bit, prev_last;
    bit          stalled[int];
    logic [127:0] gv, wv;
    logic [15:0] res;
    build_want(p, len, ce, c16);
    got.delete();
    last_pos = -1;
    @(negedge clock);
    cyc = 0;
    while (!pkt_ready && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    chk($sformatf("%s ready", tag), pkt_ready, 1);
    pkt_in    = p;
    pkt_len   = len[LEN_W-1:0];
    crc_en    = ce;
    crc16     = c16;
    pkt_valid = 1'b1;
    bs_ready  = 1'b1;
    @(negedge clock);
    pkt_valid = noise;
    if (noise) begin
      pkt_in  = ~p;
      crc_en  = ~ce;
      crc16   = ~c16;
      pkt_len = 7'd50;
    end
    chk($sformatf("%s first_valid", tag), out_valid, 1);
    fin = 0;
    prev_hold = 0;
    prev_bit = 0;
    prev_last = 0;
    cyc = 0;
    while (!fin && cyc < 2000) begin
      if (abort_at >= 0 && got.size() == abort_at) begin
        pkt_valid = 1'b0;
        return;
      end
      if (prev_hold)
        chk($sformatf("%s hold", tag), {out_valid, out_bit, out_last}, {1'b1, prev_bit, prev_last});
      n = got.size();
      if (mode == 0) bs_ready = 1'b1;
      else if (mode == 2 && (n == 3 || n == 10 || n == len + 2) && !stalled.exists(n)) begin
        bs_ready   = 1'b0;
        stalled[n] = 1;
      end else if (mode == 2 && n <= len + 2) bs_ready = 1'b1;
      else bs_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && bs_ready) begin
        got.push_back(out_bit);
        if (out_last) begin
          last_pos = got.size() - 1;
          fin = 1;
        end
      end
      prev_hold = out_valid && !bs_ready;
      prev_bit  = out_bit;
      prev_last = out_last;
      if (fin) pkt_valid = 1'b0;
      @(negedge clock);
      cyc++;
    end
    chk($sformatf("%s last_seen", tag), fin, 1);
    chk($sformatf("%s done", tag), {done, out_valid}, 2'b10);
    chk($sformatf("%s count", tag), got.size(), want_q.size());
    gv = '0;
    wv = '0;
    for (int i = 0; i < got.size() && i < 128; i++) gv[i] = got[i];
    for (int i = 0; i < want_q.size() && i < 128; i++) wv[i] = want_q[i];
    chk($sformatf("%s stream", tag), gv, wv);
    chk($sformatf("%s last_pos", tag), last_pos, want_q.size() - 1);
    if (ce && len >= PID_BITS) begin
      res = crc_over(got, PID_BITS, c16);
      chk($sformatf("%s residual", tag), res, c16 ? 16'h800D : 16'h000C);
    end
    @(negedge clock);
    chk($sformatf("%s done_drop", tag), {done, pkt_ready}, 2'b01);
  endtask

  task automatic run_err(input int len, input string tag);
    @(negedge clock);
    pkt_len   = len[LEN_W-1:0];
    pkt_in    = '1;
    crc_en    = 1'b1;
    crc16     = 1'b0;
    bs_ready  = 1'b1;
    pkt_valid = 1'b1;
    @(negedge clock);
    pkt_valid = 1'b0;
    chk($sformatf("%s pulse", tag), {len_err, out_valid, pkt_ready}, 3'b101);
    @(negedge clock);
    chk($sformatf("%s clear", tag), {len_err, out_valid, pkt_ready}, 3'b001);
  endtask

  function automatic logic [MAX_BITS-1:0] rand_pkt();
    logic [MAX_BITS-1:0] p;
    for (int i = 0; i < MAX_BITS; i++) p[i] = 1'($urandom_range(0, 1));
    return p;
  endfunction

  initial begin
    logic [MAX_BITS-1:0] p;
    int                  len;
    #3;
    chk("reset_outs", {pkt_ready, out_valid, out_last, done, len_err, out_bit}, 6'b0);
    @(negedge clock);
    reset_n = 1'b1;
    #1 chk("ready_before_clock", pkt_ready, 0);
    @(negedge clock);
    chk("ready_after_clock", pkt_ready, 1);

    p = rand_pkt();
    p[18:0] = {4'h4, 7'h05, 8'hE1};
    run_pkt(p, 19, 1, 0, 0, 0, -1, "token");
    run_pkt(p, 19, 1, 0, 2, 0, -1, "token_bp");

    p = rand_pkt();
    p[7:0] = 8'hC3;
    run_pkt(p, 40, 1, 1, 0, 0, -1, "data");
    run_pkt(p, 40, 1, 1, 2, 0, -1, "data_bp");
    run_pkt(p, 40, 1, 1, 0, 1, -1, "data_busy");

    p = rand_pkt();
    p[7:0] = 8'hD2;
    run_pkt(p, 8, 0, 0, 0, 0, -1, "handshake");
    run_pkt(p, 1, 0, 0, 0, 0, -1, "len1");
    run_pkt(p, 5, 1, 1, 0, 0, -1, "short_crc16");
    run_pkt(p, 8, 1, 0, 0, 0, -1, "pid_only_crc5");
    run_pkt(rand_pkt(), MAX_BITS, 1, 1, 1, 0, -1, "max_len");

    run_err(0, "len_zero");
    run_err(MAX_BITS + 1, "len_over");

    p = rand_pkt();
    run_pkt(p, 40, 1, 1, 0, 0, 12, "abort");
    #2 reset_n = 1'b0;
    #1 chk("abort_outs", {pkt_ready, out_valid, out_last, done, len_err, out_bit}, 6'b0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("abort_recover", {pkt_ready, out_valid}, 2'b10);
    run_pkt(p, 40, 1, 1, 0, 0, -1, "after_reset");

    for (int t = 0; t < 20; t++) begin
      len = $urandom_range(1, MAX_BITS);
      run_pkt(rand_pkt(), len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1,
              1'($urandom_range(0, 1)), -1, $sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
